// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg: shared types, key code map and lookup for the keypad scanner.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAND      = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_e;

  // Indexed [row][col], rows top-to-bottom, columns left-to-right.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[row][col];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff: width-parameterised two-flop synchronizer, resets to all-ones.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner: 4x4 matrix keypad column scan, debounce and key strobe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic          tick, scan_end;

  logic          acc_hit_q, acc_hit_d, acc_multi_q, acc_multi_d;
  logic [1:0]    acc_row_q, acc_row_d, acc_col_q, acc_col_d;
  logic [3:0]    low;
  logic [2:0]    n_low;
  logic [1:0]    row_enc;
  scan_e         res;
  logic [3:0]    key;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d, key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic          accept;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d_i   (row_n),
    .q_o   (row_s)
  );

  assign tick     = (div_q == DIV_LAST);
  assign scan_end = tick && (col_idx_q == 2'd3);
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;

  always_comb begin
    low     = ~row_s;
    n_low   = 3'd0;
    row_enc = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (low[r]) begin
        n_low   = n_low + 3'd1;
        row_enc = 2'(r);
      end
    end
  end

  // Fold the current column's sample in first so the scan-end tick sees column 3.
  always_comb begin
    acc_hit_d   = acc_hit_q;
    acc_multi_d = acc_multi_q;
    acc_row_d   = acc_row_q;
    acc_col_d   = acc_col_q;
    if (tick) begin
      if (n_low > 3'd1 || (n_low == 3'd1 && acc_hit_q)) acc_multi_d = 1'b1;
      if (n_low != 3'd0) begin
        acc_hit_d = 1'b1;
        if (!acc_hit_q) begin
          acc_row_d = row_enc;
          acc_col_d = col_idx_q;
        end
      end
    end
    res = acc_multi_d ? MULTI : (acc_hit_d ? SINGLE : NONE);
    key = key_lookup(acc_row_d, acc_col_d);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        IDLE: begin
          if (res == SINGLE) begin
            cand_d = key;
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else begin
              state_d = CAND;
              cnt_d   = CW'(1);
            end
          end
        end
        CAND: begin
          if (res == SINGLE && key == cand_q) begin
            if (cnt_q + CW'(1) == DEB_N) accept = 1'b1;
            else cnt_d = cnt_q + CW'(1);
          end else if (res == SINGLE) begin
            cand_d = key;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (res == NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASING;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASING: begin
          if (res != NONE) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == DEB_N) begin
            state_d    = IDLE;
            cnt_d      = '0;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      state_d     = PRESSED;
      cnt_d       = '0;
      key_code_d  = key;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_row_q   <= 2'd0;
      acc_col_q   <= 2'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      acc_hit_q   <= scan_end ? 1'b0 : acc_hit_d;
      acc_multi_q <= scan_end ? 1'b0 : acc_multi_d;
      acc_row_q   <= scan_end ? 2'd0 : acc_row_d;
      acc_col_q   <= scan_end ? 2'd0 : acc_col_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

`default_nettype wire
